// File: rtl/load_store_unit.sv
// Load/store unit: sequences CPU byte/halfword/word accesses onto a
// word-wide data memory. Sub-word stores do a read-modify-write.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned accesses fault).
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, next_state;
    logic        we_q, uns_q, fault_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, old_q, rdata_q;
    logic        accept, misalign, fault_req;
    logic [31:0] byte_sh, half_sh, load_data, merged;

    assign accept = req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault_req = (req_size == 2'b11) || misalign;

    // State register, request capture and read-data / old-word capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                fault_q <= fault_req;
                rdata_q <= '0;
            end
            if (state == RD) begin
                if (we_q) old_q   <= mem_rdata;
                else      rdata_q <= load_data;
            end
        end
    end

    // Next-state logic, lane extraction/merge and memory/response outputs
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
        half_sh = mem_rdata >> {addr_q[1], 4'b0000};
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, byte_sh[7:0]}
                                       : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_data = uns_q ? {16'b0, half_sh[15:0]}
                                       : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_data = mem_rdata;
        endcase

        merged = old_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault_req)                      next_state = RESP;
                    else if (req_we && req_size == 2'b10) next_state = WR;
                    else                                next_state = RD;
                end
            end
            RD: begin
                mem_read   = 1'b1;
                mem_addr   = {addr_q[31:2], 2'b00};
                next_state = we_q ? WR : RESP;
            end
            WR: begin
                mem_write  = 1'b1;
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_wdata  = merged;
                next_state = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = rdata_q;
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expectations,
// a monitor compares responses, latency and memory traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [16];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          nrd = 0;
    int          nwr = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t q[$];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample after each rising edge
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                if (q.size() == 0) chk("unexpected_mem_write", 32'd1, 32'd0);
                else begin
                    chk("mem_addr", mem_addr, q[0].waddr);
                    chk("mem_wdata", mem_wdata, q[0].wdata);
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                    chk("latency", cyc - e.acc, e.lat);
                    chk("mem_read_cycles", nrd, e.rd);
                    chk("mem_write_cycles", nwr, e.wr);
                end
                nrd = 0;
                nwr = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erdata, input logic efault, input int lat,
                         input int rd, input int wr, input logic [31:0] waddr,
                         input logic [31:0] ewdata);
        exp_t e;
        int   t;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        e.rdata = erdata; e.fault = efault; e.lat = lat; e.rd = rd; e.wr = wr;
        e.waddr = waddr; e.wdata = ewdata; e.acc = cyc;
        q.push_back(e);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_size = 2'b11; req_addr = 32'hFFFF_FFFF;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("response_timeout", 32'd1, 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        mem[4] = 32'h8899_AABB;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp", {resp_valid, resp_fault, mem_read, mem_write}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // loads on 0x8899AABB
        issue(0, 2'b00, 0, 32'h11, 0, 32'hFFFF_FFAA, 0, 2, 1, 0, 0, 0);
        issue(0, 2'b01, 1, 32'h12, 0, 32'h0000_8899, 0, 2, 1, 0, 0, 0);
        issue(0, 2'b00, 1, 32'h10, 0, 32'h0000_00BB, 0, 2, 1, 0, 0, 0);
        issue(0, 2'b00, 0, 32'h13, 0, 32'hFFFF_FF88, 0, 2, 1, 0, 0, 0);
        issue(0, 2'b01, 0, 32'h10, 0, 32'hFFFF_AABB, 0, 2, 1, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'h8899_AABB, 0, 2, 1, 0, 0, 0);
        issue(0, 2'b00, 1, 32'h12, 0, 32'h0000_0099, 0, 2, 1, 0, 0, 0);

        // sub-word stores (read-modify-write)
        issue(1, 2'b00, 0, 32'h13, 32'hFFFF_FF55, 0, 0, 3, 1, 1, 32'h10, 32'h5599_AABB);
        chk("mem10_after_sb", mem[4], 32'h5599_AABB);
        issue(1, 2'b01, 0, 32'h10, 32'hABCD_1234, 0, 0, 3, 1, 1, 32'h10, 32'h5599_1234);
        chk("mem10_after_sh", mem[4], 32'h5599_1234);

        // misaligned word store / halfword load, illegal size
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1, 2'b10, 0, 32'h06, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 0, 0);
        chk("mem04_untouched", mem[1], 32'h0);
        issue(0, 2'b01, 1, 32'h11, 0, 0, 1, 1, 0, 0, 0, 0);
`else
        issue(1, 2'b10, 0, 32'h06, 32'hDEAD_BEEF, 0, 0, 2, 0, 1, 32'h04, 32'hDEAD_BEEF);
        chk("mem04_written", mem[1], 32'hDEAD_BEEF);
        issue(0, 2'b01, 1, 32'h11, 0, 32'h0000_1234, 0, 2, 1, 0, 0, 0);
`endif
        issue(0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0, 0, 0, 0);
        issue(1, 2'b11, 0, 32'h10, 32'h1111_1111, 0, 1, 1, 0, 0, 0, 0);
        chk("mem10_after_illegal", mem[4], 32'h5599_1234);

        // reset while a byte store sits in RD
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h13; req_wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_rd", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_outputs", {resp_valid, resp_fault, mem_read, mem_write}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_mem10_unchanged", mem[4], 32'h5599_1234);
        chk("abort_idle_ready", {31'b0, req_ready}, 32'd1);

        issue(0, 2'b10, 0, 32'h10, 0, 32'h5599_1234, 0, 2, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit address/data, byte lanes little-endian).
REQ-002 SHALL provide: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide: req_valid  input  1  CPU access request present.
REQ-005 SHALL provide: req_ready  output  1  unit can accept request (IDLE only).
REQ-006 SHALL provide: req_we  input  1  1=store, 0=load.
REQ-007 SHALL provide: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL provide: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL provide: req_addr  input  32  byte address; req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL provide: resp_valid  output  1  one-cycle completion pulse; resp_rdata  output  32  extended load data; resp_fault  output  1  access rejected.
REQ-011 SHALL provide: mem_read  output  1; mem_write  output  1; mem_addr  output  32; mem_wdata  output  32; mem_rdata  input  32 -- word-interface to data memory (combinational read, write on clk edge).

Function
REQ-012 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-013 SHALL latch we/size/unsigned/addr/wdata on req_valid&&req_ready; inputs ignored in other states.
REQ-014 Accepted at edge N: load -> RD -> RESP; resp_valid high cycle N+2.
REQ-015 Word store -> WR -> RESP; resp_valid at N+2; mem_write high exactly one cycle (WR).
REQ-016 Byte/halfword store -> RD (capture old word) -> WR (merged word) -> RESP; resp_valid at N+3.
REQ-017 mem_addr SHALL be {addr[31:2],2'b00} in RD/WR, 0 otherwise; mem_read=1 only in RD; mem_write=1 only in WR; mem_wdata=0 outside WR.
REQ-018 Load extraction: byte lane addr[1:0], halfword lane addr[1]; extended per req_unsigned; word unmodified.
REQ-019 Store merge: only addressed byte/halfword lane replaced by low bits of req_wdata; other lanes keep RD-captured value.
REQ-020 resp_rdata SHALL be registered, valid only with resp_valid, 0 for stores and faults.
REQ-021 req_size=11 SHALL skip memory (no mem_read/mem_write), go IDLE->RESP, resp_valid and resp_fault at N+1.
REQ-022 RESP SHALL always return to IDLE; back-to-back request accepted no earlier than cycle after RESP.

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE and clear all outputs: req_ready=1 after reset, resp_valid=0, resp_fault=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-024 Reset in RD or WR SHALL abandon the access; no mem_write asserted afterward for that request; no resp_valid issued.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL fault like REQ-021 (no memory access, fault at N+1).
REQ-026 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned low bits ignored (halfword uses addr[1] only, word uses aligned address); resp_fault only for size=11.

Verification
REQ-027 Mem[0x10]=0x8899AABB; load byte signed addr 0x11 -> resp_rdata=0xFFFFFFAA at N+2, mem_read high only cycle N+1.
REQ-028 Same memory; load halfword unsigned addr 0x12 -> resp_rdata=0x00008899 at N+2, resp_fault=0.
REQ-029 Store byte 0x55 to addr 0x13 -> one mem_write with mem_wdata=0x5599AABB at mem_addr 0x10, resp_valid at N+3.
REQ-030 With LSU_MISALIGN_TRAP_EN, store word addr 0x06 -> resp_fault=1 at N+1, mem_write never asserted; without macro -> word written to 0x04.
REQ-031 rst_n low during RD of store byte to 0x13 -> mem_write stays 0, Mem[0x10] unchanged, req_ready=1 after reset.
REQ-032 req_size=11 load -> resp_valid=resp_fault=1 at N+1, resp_rdata=0, mem_read never asserted.
